// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared defaults for sram_fifo_ctrl (word/address width, depth derivation, occupancy width)
package sram_fifo_pkg;
    localparam int SF_DW = 4;
    localparam int SF_AW = 4;
    function automatic int depth_of(input int aw);
        return 2 ** aw;
    endfunction
    localparam int SF_DEPTH = depth_of(SF_AW);
    localparam int SF_CW = SF_AW + 1;
endpackage

// File: rtl/sram_fifo_obuf.sv
// sram_fifo_obuf: 2-entry output buffer (clk, rst_n; push/wdata append, pop shifts, cnt occupancy, head = oldest word)
module sram_fifo_obuf #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [1:0]    cnt,
    output logic [DW-1:0] head
);
    logic [DW-1:0] ob0, ob1;
    logic [1:0]    base;
    assign base = cnt - {1'b0, pop};
    assign head = ob0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ob0 <= '0;
            ob1 <= '0;
        end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (pop) ob0 <= ob1;
            if (push && base == 2'd0) ob0 <= wdata;
            if (push && base != 2'd0) ob1 <= wdata;
        end
    end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO over a 1-port 1-cycle-read SRAM (push_valid/ready/data in, pop_valid/ready/data out, count, ram_we/addr/wdata/rdata); SRAM_FIFO_BYPASS_EN lets pushes skip the RAM when it is empty
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DW = SF_DW,
    parameter int AW = SF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_data,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [DW-1:0] pop_data,
    output logic [AW:0]   count,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    localparam int DEPTH = depth_of(AW);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   mem_cnt;
    logic          inflight;
    logic [1:0]    ob_cnt;
    logic          read_issue, byp, push_fire, pop_fire, ram_wr, ob_push;
    logic [DW-1:0] ob_wdata;
`ifdef SRAM_FIFO_BYPASS_EN
    assign byp = (mem_cnt == '0) && !inflight && (ob_cnt < 2'd2);
`else
    assign byp = 1'b0;
`endif
    assign read_issue = (mem_cnt != '0) && ((ob_cnt + {1'b0, inflight}) < 2'd2);
    assign push_ready = rst_n && (byp || ((mem_cnt < DEPTH_C) && !read_issue));
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;
    assign ram_wr     = push_fire && !byp;
    assign ram_we     = ram_wr;
    assign ram_addr   = ram_wr ? wr_ptr : rd_ptr;
    assign ram_wdata  = push_data;
    assign ob_push    = inflight || (push_fire && byp);
    assign ob_wdata   = inflight ? ram_rdata : push_data;
    assign pop_valid  = ob_cnt != 2'd0;
    assign count      = mem_cnt + {{AW{1'b0}}, inflight} + {{(AW-1){1'b0}}, ob_cnt};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= read_issue;
            if (ram_wr) wr_ptr <= wr_ptr + 1'b1;
            if (read_issue) rd_ptr <= rd_ptr + 1'b1;
            mem_cnt <= mem_cnt + {{AW{1'b0}}, ram_wr} - {{AW{1'b0}}, read_issue};
        end
    end
    sram_fifo_obuf #(.DW(DW)) u_obuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ob_push),
        .wdata (ob_wdata),
        .pop   (pop_fire),
        .cnt   (ob_cnt),
        .head  (pop_data)
    );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: scoreboard bench for sram_fifo_ctrl with a behavioural 16x4 read-first SRAM
module tb_sram_fifo_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, push_valid = 1'b0, pop_ready = 1'b0;
    logic [3:0] push_data = '0;
    logic       push_ready, pop_valid, ram_we;
    logic [3:0] pop_data, ram_addr, ram_wdata, ram_rdata;
    logic [4:0] count;
    logic [3:0] mem [16];
    int         ncmp = 0, nerr = 0, model_cnt = 0;
    logic [3:0] exp_q [$];
    logic       hold = 1'b0;
    logic [3:0] hold_data = '0;
    always #5 clk = ~clk;
    sram_fifo_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .count      (count),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end
    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", int'(count), model_cnt);
            if (hold) begin
                chk("hold_valid", int'(pop_valid), 1);
                chk("hold_data", int'(pop_data), int'(hold_data));
            end
            if (pop_valid && pop_ready) begin
                chk("pop_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("pop_data", int'(pop_data), int'(exp_q.pop_front()));
            end
            if (push_valid && push_ready) exp_q.push_back(push_data);
            model_cnt += int'(push_valid && push_ready) - int'(pop_valid && pop_ready);
            hold = pop_valid && !pop_ready;
            hold_data = pop_data;
        end else begin
            hold = 1'b0;
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic push_word(input logic [3:0] d);
        logic ok;
        ok = 1'b0;
        push_valid = 1'b1;
        push_data = d;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (push_ready) ok = 1'b1;
            cyc();
        end
        push_valid = 1'b0;
        chk("push_accept", int'(ok), 1);
    endtask
    task automatic drain();
        pop_ready = 1'b1;
        for (int i = 0; i < 100 && count != 0; i++) cyc();
        cyc();
        pop_ready = 1'b0;
        chk("drain_count", int'(count), 0);
        chk("drain_queue", exp_q.size(), 0);
    endtask
    initial begin
        logic f;
        logic [3:0] fill [18];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_pop_valid", int'(pop_valid), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_push_ready", int'(push_ready), 0);
        rst_n = 1'b1;
        cyc();
        push_data = 4'h3;
        push_valid = 1'b1;
        #1;
        chk("single_we", int'(ram_we), 1);
        chk("single_waddr", int'(ram_addr), 0);
        chk("single_ready", int'(push_ready), 1);
        cyc();
        push_valid = 1'b0;
        #1;
        chk("single_rd_we", int'(ram_we), 0);
        chk("single_raddr", int'(ram_addr), 0);
        chk("single_rd_ready", int'(push_ready), 0);
        chk("single_early_valid", int'(pop_valid), 0);
        cyc();
        chk("single_inflight_valid", int'(pop_valid), 0);
        cyc();
        chk("single_valid", int'(pop_valid), 1);
        chk("single_data", int'(pop_data), 3);
        pop_ready = 1'b1;
        repeat (4) cyc();
        chk("empty_pop_count", int'(count), 0);
        chk("empty_pop_valid", int'(pop_valid), 0);
        pop_ready = 1'b0;
        for (int i = 0; i < 16; i++) fill[i] = 4'(i);
        fill[16] = 4'h1;
        fill[17] = 4'h2;
        for (int i = 0; i < 18; i++) push_word(fill[i]);
        repeat (3) cyc();
        chk("full_count", int'(count), 18);
        chk("full_ready", int'(push_ready), 0);
        chk("full_head", int'(pop_data), 0);
        push_valid = 1'b1;
        push_data = 4'h9;
        repeat (3) cyc();
        chk("full_ready_held", int'(push_ready), 0);
        push_valid = 1'b0;
        drain();
        push_data = 4'h0;
        push_valid = 1'b1;
        pop_ready = 1'b1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            f = push_ready;
            cyc();
            if (f) push_data = push_data + 4'h1;
        end
        push_valid = 1'b0;
        drain();
        for (int i = 5; i < 10; i++) push_word(4'(i));
        rst_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_valid", int'(pop_valid), 0);
        chk("midrst_ready", int'(push_ready), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        push_word(4'hA);
        for (int i = 0; i < 10 && !pop_valid; i++) cyc();
        chk("post_rst_valid", int'(pop_valid), 1);
        chk("post_rst_data", int'(pop_data), 10);
        drain();
        for (int i = 0; i < 2000; i++) begin
            int p;
            p = 30 + 10 * (i / 500);
            push_valid = $urandom_range(0, 99) < p;
            pop_ready = $urandom_range(0, 99) < (100 - p);
            push_data = 4'($urandom);
            cyc();
        end
        push_valid = 1'b0;
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
